// File: rtl/record_store_pkg.sv
// Shared types and constants for the record/chart slot stores.
// Optional feature macro: RECORD_STORE_PRELOAD_EN (demo preload table).
package record_store_pkg;

  localparam int CHARTS_MAX    = 8;
  localparam int PLAY_RECS_MAX = 16;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  typedef struct packed {
    logic [15:0] chart_id;
    logic [7:0]  level;
    logic [7:0]  flags;
  } ChartInfo;

  typedef struct packed {
    ChartInfo     info;
    logic [127:0] notes;
  } Chart;

  typedef struct packed {
    logic [15:0] chart_id;
    logic [31:0] score;
    logic [15:0] max_combo;
    logic [7:0]  grade;
    logic [87:0] reserved;
  } PlayRecord;

`ifdef RECORD_STORE_PRELOAD_EN
  localparam int DEMO_W = 160;

  // Demo table; each instance keeps the low DATA_W bits of an entry.
  function automatic logic [DEMO_W-1:0] demo_value(input int unsigned idx);
    logic [DEMO_W-1:0] v;
    case (idx)
      32'd0:   v = 160'h0001_0000_0000_0000_0000_0000_0000_0000_0000_D001;
      32'd1:   v = 160'h0002_0000_0000_0000_0000_0000_0000_0000_0000_D002;
      32'd2:   v = 160'h0003_0000_0000_0000_0000_0000_0000_0000_0000_D003;
      32'd3:   v = 160'h0004_0000_0000_0000_0000_0000_0000_0000_0000_D004;
      default: v = {DEMO_W{1'b0}};
    endcase
    return v;
  endfunction
`endif

endpackage

// File: rtl/record_store_ram.sv
// DEPTH x DATA_W storage, one read and one write port, synchronous
// read-before-write (a same-address read returns the old word).
module record_store_ram #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 160,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Registered read; the output holds until the next enabled read.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  // Write port; nonblocking update keeps same-cycle reads on old data.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/record_store.sv
// Generic slot store with 1-based ids, valid bits, occupancy count,
// ring-pointer append and a one-slot-per-cycle init sweep.
// Optional feature macro: RECORD_STORE_PRELOAD_EN (sweep writes demo table).
module record_store
  import record_store_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 160,
  parameter int ID_W      = $clog2(DEPTH + 1),
  parameter int OVERWRITE = 1
`ifdef RECORD_STORE_PRELOAD_EN
  , parameter int PRELOAD_CNT = 2
`endif
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              rd_req,
  input  logic [ID_W-1:0]   rd_id,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ID_W-1:0]   wr_id,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              wr_err,
  output logic [ID_W-1:0]   wr_slot,
  output logic              rdy,
  output logic [ID_W-1:0]   count,
  output logic              full
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [ID_W-1:0] DEPTH_ID = ID_W'(DEPTH);
  localparam logic [ID_W-1:0] ONE_ID   = ID_W'(1);
  localparam logic [ID_W-1:0] ZERO_ID  = {ID_W{1'b0}};
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0]   ZERO_IDX = {AW{1'b0}};

  state_e              state_q, state_d;
  logic [AW-1:0]       init_idx_q, init_idx_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ID_W-1:0]     count_q, count_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic                rdy_q, rdy_d;
  logic                full_q, full_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_err_q, rd_err_d;
  logic                rd_ok_q, rd_ok_d;
  logic                wr_done_q, wr_done_d;
  logic                wr_err_q, wr_err_d;
  logic [ID_W-1:0]     wr_slot_q, wr_slot_d;

  logic                ram_re_s, ram_we_s;
  logic [AW-1:0]       ram_raddr_s, ram_waddr_s;
  logic [DATA_W-1:0]   ram_wdata_s, ram_rdata_s;
  logic [DATA_W-1:0]   init_data_s;
  logic                init_valid_s;
  logic [AW-1:0]       init_ptr_s;
  logic [AW-1:0]       rd_idx_s, wr_idx_s, wr_tgt_s;
  logic                rd_in_range_s, wr_ok_s, wr_adv_s;

`ifdef RECORD_STORE_PRELOAD_EN
  logic [DEMO_W-1:0]   demo_s;

  // Demo contents for the slot being swept; first PRELOAD_CNT slots become valid.
  always_comb begin
    demo_s       = demo_value(int'(init_idx_q));
    init_data_s  = DATA_W'(demo_s);
    init_valid_s = (int'(init_idx_q) < PRELOAD_CNT);
    init_ptr_s   = AW'(PRELOAD_CNT % DEPTH);
  end
`else
  // Plain sweep clears every slot and leaves the store empty.
  always_comb begin
    init_data_s  = {DATA_W{1'b0}};
    init_valid_s = 1'b0;
    init_ptr_s   = ZERO_IDX;
  end
`endif

  // Decode request ids and resolve the write target (append or in place).
  always_comb begin
    rd_idx_s      = AW'(rd_id - ONE_ID);
    wr_idx_s      = AW'(wr_id - ONE_ID);
    rd_in_range_s = (rd_id != ZERO_ID) && (rd_id <= DEPTH_ID);
    if (wr_id == ZERO_ID) begin
      wr_tgt_s = wr_ptr_q;
      wr_ok_s  = !valid_q[wr_ptr_q] || (OVERWRITE != 0);
      wr_adv_s = wr_ok_s;
    end else if (wr_id <= DEPTH_ID) begin
      wr_tgt_s = wr_idx_s;
      wr_ok_s  = 1'b1;
      wr_adv_s = 1'b0;
    end else begin
      wr_tgt_s = ZERO_IDX;
      wr_ok_s  = 1'b0;
      wr_adv_s = 1'b0;
    end
  end

  // Next-state logic: init sweep, then concurrent read and write service.
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    valid_d     = valid_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_valid_d  = 1'b0;
    rd_err_d    = rd_err_q;
    rd_ok_d     = rd_ok_q;
    wr_done_d   = 1'b0;
    wr_err_d    = wr_err_q;
    wr_slot_d   = wr_slot_q;
    ram_re_s    = 1'b0;
    ram_raddr_s = ZERO_IDX;
    ram_we_s    = 1'b0;
    ram_waddr_s = ZERO_IDX;
    ram_wdata_s = {DATA_W{1'b0}};
    case (state_q)
      INIT: begin
        ram_we_s             = 1'b1;
        ram_waddr_s          = init_idx_q;
        ram_wdata_s          = init_data_s;
        valid_d[init_idx_q]  = init_valid_s;
        count_d              = count_q + (init_valid_s ? ONE_ID : ZERO_ID);
        if (init_idx_q == LAST_IDX) begin
          state_d    = IDLE;
          init_idx_d = ZERO_IDX;
          wr_ptr_d   = init_ptr_s;
        end else begin
          init_idx_d = init_idx_q + AW'(1);
        end
      end
      IDLE: begin
        if (rd_req) begin
          // Valid bit is sampled before this cycle's write lands.
          rd_valid_d  = 1'b1;
          rd_ok_d     = rd_in_range_s && valid_q[rd_idx_s];
          rd_err_d    = !(rd_in_range_s && valid_q[rd_idx_s]);
          ram_re_s    = rd_in_range_s;
          ram_raddr_s = rd_idx_s;
        end else begin
          rd_valid_d  = 1'b0;
        end
        if (wr_req) begin
          wr_done_d = 1'b1;
          wr_err_d  = !wr_ok_s;
          if (wr_ok_s) begin
            ram_we_s          = 1'b1;
            ram_waddr_s       = wr_tgt_s;
            ram_wdata_s       = wr_data;
            valid_d[wr_tgt_s] = 1'b1;
            count_d           = count_q + (valid_q[wr_tgt_s] ? ZERO_ID : ONE_ID);
            wr_slot_d         = ID_W'(wr_tgt_s) + ONE_ID;
          end else begin
            wr_slot_d         = ZERO_ID;
          end
          if (wr_adv_s) begin
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? ZERO_IDX : (wr_ptr_q + AW'(1));
          end else begin
            wr_ptr_d = wr_ptr_q;
          end
        end else begin
          wr_done_d = 1'b0;
        end
      end
      default: begin
        state_d    = INIT;
        init_idx_d = ZERO_IDX;
      end
    endcase
    full_d = (count_d == DEPTH_ID);
    rdy_d  = (state_d == IDLE);
  end

  // State and output registers; reset restarts the sweep and drops pulses.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state_q    <= INIT;
      init_idx_q <= ZERO_IDX;
      valid_q    <= {DEPTH{1'b0}};
      count_q    <= ZERO_ID;
      wr_ptr_q   <= ZERO_IDX;
      rdy_q      <= 1'b0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_ok_q    <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      wr_slot_q  <= ZERO_ID;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rdy_q      <= rdy_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_ok_q    <= rd_ok_d;
      wr_done_q  <= wr_done_d;
      wr_err_q   <= wr_err_d;
      wr_slot_q  <= wr_slot_d;
    end
  end

  record_store_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk_i   (clk),
    .re_i    (ram_re_s),
    .raddr_i (ram_raddr_s),
    .rdata_o (ram_rdata_s),
    .we_i    (ram_we_s & sys_rst_n),
    .waddr_i (ram_waddr_s),
    .wdata_i (ram_wdata_s)
  );

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = rd_ok_q ? ram_rdata_s : {DATA_W{1'b0}};
  assign wr_done  = wr_done_q;
  assign wr_err   = wr_err_q;
  assign wr_slot  = wr_slot_q;
  assign rdy      = rdy_q;
  assign count    = count_q;
  assign full     = full_q;

endmodule

// File: tb/tb_record_store.sv
// Scoreboard bench for record_store: two instances (OVERWRITE=1 as "a",
// OVERWRITE=0 as "b") share one stimulus stream; expected results are
// queued at issue time and checked by a monitor on each output pulse.
module tb_record_store;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic [2:0]  rd_id = 3'd0, wr_id = 3'd0;
  logic [15:0] wr_data = 16'd0;

  logic        rd_valid_a, rd_err_a, wr_done_a, wr_err_a, rdy_a, full_a;
  logic [15:0] rd_data_a;
  logic [2:0]  wr_slot_a, count_a;
  logic        rd_valid_b, rd_err_b, wr_done_b, wr_err_b, rdy_b, full_b;
  logic [15:0] rd_data_b;
  logic [2:0]  wr_slot_b, count_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] rdq_a[$], rdq_b[$];   // {err, data}
  logic [7:0]  wrq_a[$], wrq_b[$];   // {err, slot, count, full}

  always #5 clk = ~clk;

  record_store #(.DEPTH(4), .DATA_W(16), .OVERWRITE(1)
`ifdef RECORD_STORE_PRELOAD_EN
    , .PRELOAD_CNT(2)
`endif
  ) dut_a (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .rd_req(rd_req), .rd_id(rd_id), .rd_valid(rd_valid_a), .rd_err(rd_err_a), .rd_data(rd_data_a),
    .wr_req(wr_req), .wr_id(wr_id), .wr_data(wr_data), .wr_done(wr_done_a), .wr_err(wr_err_a),
    .wr_slot(wr_slot_a), .rdy(rdy_a), .count(count_a), .full(full_a)
  );

  record_store #(.DEPTH(4), .DATA_W(16), .OVERWRITE(0)
`ifdef RECORD_STORE_PRELOAD_EN
    , .PRELOAD_CNT(2)
`endif
  ) dut_b (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .rd_req(rd_req), .rd_id(rd_id), .rd_valid(rd_valid_b), .rd_err(rd_err_b), .rd_data(rd_data_b),
    .wr_req(wr_req), .wr_id(wr_id), .wr_data(wr_data), .wr_done(wr_done_b), .wr_err(wr_err_b),
    .wr_slot(wr_slot_b), .rdy(rdy_b), .count(count_b), .full(full_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: pulse seen with no expected entry queued", name);
  endtask

  function automatic logic [16:0] re(input logic err, input logic [15:0] data);
    return {err, data};
  endfunction

  function automatic logic [7:0] we(input logic err, input logic [2:0] slot,
                                    input logic [2:0] cnt, input logic fl);
    return {err, slot, cnt, fl};
  endfunction

  task automatic exp_rd(input logic [16:0] ea, input logic [16:0] eb);
    rdq_a.push_back(ea);
    rdq_b.push_back(eb);
  endtask

  task automatic exp_wr(input logic [7:0] ea, input logic [7:0] eb);
    wrq_a.push_back(ea);
    wrq_b.push_back(eb);
  endtask

  // One request cycle: inputs applied at a negedge, sampled at the next posedge.
  task automatic cyc(input logic r, input logic [2:0] rid, input logic w,
                     input logic [2:0] wid, input logic [15:0] wd);
    rd_req = r; rd_id = rid; wr_req = w; wr_id = wid; wr_data = wd;
    @(negedge clk);
  endtask

  // Called at the negedge where reset is released; counts low-rdy cycles.
  task automatic wait_ready();
    int low;
    low = 0;
    for (int i = 0; i < 20 && !(rdy_a && rdy_b); i++) begin
      low++;
      @(negedge clk);
    end
    chk("init_rdy_low_cycles", low, 32'd4);
    chk("rdy_a_after_init", rdy_a, 32'd1);
    chk("rdy_b_after_init", rdy_b, 32'd1);
  endtask

  // Monitor: pop and compare whenever either instance pulses.
  always @(negedge clk) begin
    if (rd_valid_a) begin
      if (rdq_a.size() == 0) unexpected("rd_a");
      else chk("rd_a {err,data}", {15'd0, rd_err_a, rd_data_a}, {15'd0, rdq_a.pop_front()});
    end
    if (rd_valid_b) begin
      if (rdq_b.size() == 0) unexpected("rd_b");
      else chk("rd_b {err,data}", {15'd0, rd_err_b, rd_data_b}, {15'd0, rdq_b.pop_front()});
    end
    if (wr_done_a) begin
      if (wrq_a.size() == 0) unexpected("wr_a");
      else chk("wr_a {err,slot,count,full}", {24'd0, wr_err_a, wr_slot_a, count_a, full_a},
               {24'd0, wrq_a.pop_front()});
    end
    if (wr_done_b) begin
      if (wrq_b.size() == 0) unexpected("wr_b");
      else chk("wr_b {err,slot,count,full}", {24'd0, wr_err_b, wr_slot_b, count_b, full_b},
               {24'd0, wrq_b.pop_front()});
    end
  end

  initial begin
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdy_a", rdy_a, 32'd0);
    chk("reset_rdy_b", rdy_b, 32'd0);
    chk("reset_count_a", count_a, 32'd0);
    chk("reset_full_a", full_a, 32'd0);
    chk("reset_pulses_a", {rd_valid_a, wr_done_a, rd_err_a, wr_err_a}, 32'd0);
    chk("reset_rd_data_a", rd_data_a, 32'd0);
    chk("reset_wr_slot_a", wr_slot_a, 32'd0);

    sys_rst_n = 1'b1;
    wait_ready();

`ifdef RECORD_STORE_PRELOAD_EN
    chk("preload_count_a", count_a, 32'd2);
    chk("preload_count_b", count_b, 32'd2);
    chk("preload_full_a", full_a, 32'd0);
    exp_rd(re(1'b0, 16'hD001), re(1'b0, 16'hD001));
    cyc(1'b1, 3'd1, 1'b0, 3'd0, 16'd0);
    exp_rd(re(1'b0, 16'hD002), re(1'b0, 16'hD002));
    cyc(1'b1, 3'd2, 1'b0, 3'd0, 16'd0);
    exp_rd(re(1'b1, 16'h0000), re(1'b1, 16'h0000));
    cyc(1'b1, 3'd3, 1'b0, 3'd0, 16'd0);
    exp_wr(we(1'b0, 3'd3, 3'd3, 1'b0), we(1'b0, 3'd3, 3'd3, 1'b0));
    cyc(1'b0, 3'd0, 1'b1, 3'd0, 16'h0077);
    exp_rd(re(1'b0, 16'h0077), re(1'b0, 16'h0077));
    cyc(1'b1, 3'd3, 1'b0, 3'd0, 16'd0);
`else
    chk("init_count_a", count_a, 32'd0);
    chk("init_count_b", count_b, 32'd0);

    // Read of an empty slot.
    exp_rd(re(1'b1, 16'h0000), re(1'b1, 16'h0000));
    cyc(1'b1, 3'd1, 1'b0, 3'd0, 16'd0);

    // Four back-to-back appends fill the store.
    exp_wr(we(1'b0, 3'd1, 3'd1, 1'b0), we(1'b0, 3'd1, 3'd1, 1'b0));
    cyc(1'b0, 3'd0, 1'b1, 3'd0, 16'h00A1);
    exp_wr(we(1'b0, 3'd2, 3'd2, 1'b0), we(1'b0, 3'd2, 3'd2, 1'b0));
    cyc(1'b0, 3'd0, 1'b1, 3'd0, 16'h00A2);
    exp_wr(we(1'b0, 3'd3, 3'd3, 1'b0), we(1'b0, 3'd3, 3'd3, 1'b0));
    cyc(1'b0, 3'd0, 1'b1, 3'd0, 16'h00A3);
    exp_wr(we(1'b0, 3'd4, 3'd4, 1'b1), we(1'b0, 3'd4, 3'd4, 1'b1));
    cyc(1'b0, 3'd0, 1'b1, 3'd0, 16'h00A4);

    // Fifth append: a wraps onto slot 1, b rejects.
    exp_wr(we(1'b0, 3'd1, 3'd4, 1'b1), we(1'b1, 3'd0, 3'd4, 1'b1));
    cyc(1'b0, 3'd0, 1'b1, 3'd0, 16'h00A5);
    exp_rd(re(1'b0, 16'h00A5), re(1'b0, 16'h00A1));
    cyc(1'b1, 3'd1, 1'b0, 3'd0, 16'd0);

    // Same-slot read and in-place write: read sees pre-write data.
    exp_rd(re(1'b0, 16'h00A3), re(1'b0, 16'h00A3));
    exp_wr(we(1'b0, 3'd3, 3'd4, 1'b1), we(1'b0, 3'd3, 3'd4, 1'b1));
    cyc(1'b1, 3'd3, 1'b1, 3'd3, 16'hBEEF);
    exp_rd(re(1'b0, 16'hBEEF), re(1'b0, 16'hBEEF));
    cyc(1'b1, 3'd3, 1'b0, 3'd0, 16'd0);

    // Out-of-range ids on both ports.
    exp_rd(re(1'b1, 16'h0000), re(1'b1, 16'h0000));
    exp_wr(we(1'b1, 3'd0, 3'd4, 1'b1), we(1'b1, 3'd0, 3'd4, 1'b1));
    cyc(1'b1, 3'd5, 1'b1, 3'd7, 16'h1234);
    exp_rd(re(1'b0, 16'h00A2), re(1'b0, 16'h00A2));
    cyc(1'b1, 3'd2, 1'b0, 3'd0, 16'd0);

    // Next append: a's pointer is at slot 2, b's is still at slot 1.
    exp_wr(we(1'b0, 3'd2, 3'd4, 1'b1), we(1'b1, 3'd0, 3'd4, 1'b1));
    cyc(1'b0, 3'd0, 1'b1, 3'd0, 16'h00C6);
    exp_rd(re(1'b0, 16'h00C6), re(1'b0, 16'h00A2));
    cyc(1'b1, 3'd2, 1'b0, 3'd0, 16'd0);
    cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'd0);
    chk("rd_data_held_a", rd_data_a, 32'h00C6);
    chk("rd_data_held_b", rd_data_b, 32'h00A2);

    // Reset in the middle of a request: no pulses, sweep replays.
    rd_req = 1'b1; rd_id = 3'd1; wr_req = 1'b1; wr_id = 3'd0; wr_data = 16'h0099;
    sys_rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_pulses_a", {rd_valid_a, wr_done_a}, 32'd0);
    chk("midreset_pulses_b", {rd_valid_b, wr_done_b}, 32'd0);
    chk("midreset_count_a", count_a, 32'd0);
    chk("midreset_rdy_a", rdy_a, 32'd0);
    cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'd0);
    sys_rst_n = 1'b1;
    wait_ready();
    chk("reinit_count_a", count_a, 32'd0);
    chk("reinit_full_a", full_a, 32'd0);
    exp_rd(re(1'b1, 16'h0000), re(1'b1, 16'h0000));
    cyc(1'b1, 3'd1, 1'b0, 3'd0, 16'd0);
    exp_wr(we(1'b0, 3'd1, 3'd1, 1'b0), we(1'b0, 3'd1, 3'd1, 1'b0));
    cyc(1'b0, 3'd0, 1'b1, 3'd0, 16'h0055);
    exp_rd(re(1'b0, 16'h0055), re(1'b0, 16'h0055));
    cyc(1'b1, 3'd1, 1'b0, 3'd0, 16'd0);
`endif

    repeat (3) cyc(1'b0, 3'd0, 1'b0, 3'd0, 16'd0);
    chk("rdq_a_drained", rdq_a.size(), 32'd0);
    chk("rdq_b_drained", rdq_b.size(), 32'd0);
    chk("wrq_a_drained", wrq_a.size(), 32'd0);
    chk("wrq_b_drained", wrq_b.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/record_store.md
Name: record_store

Overview:
- Parametrised successor to the fixed chart/record storage managers: a generic DEPTH x DATA_W slot store with 1-based slot ids.
- Adds per-slot valid bits, occupancy count, an append mode with ring-pointer placement, error flags and a timed init sweep.
- Sits between the game/record FSMs and the UI. It is instantiated once for play records and once for charts, each with its own DATA_W.

Parameters:
DEPTH, 8, number of slots (>=2).
DATA_W, 160, bits per slot (packed PlayRecord/Chart width).
ID_W, $clog2(DEPTH+1), slot id width; id 0 means "none/append".
OVERWRITE, 1, when 1 append overwrites oldest occupied slot when full; when 0 append to an occupied slot is rejected.

Ports:
clk  in  1  system clock
sys_rst_n  in  1  synchronous active-low reset
rd_req  in  1  read request, sampled when rdy=1
rd_id  in  ID_W  slot to read, 1..DEPTH
rd_valid  out  1  one-cycle pulse, read result valid
rd_err  out  1  qualifies rd_valid: id out of range or slot empty
rd_data  out  DATA_W  read data, zero on error, held between reads
wr_req  in  1  write request, sampled when rdy=1
wr_id  in  ID_W  0 = append, 1..DEPTH = write in place
wr_data  in  DATA_W  write data
wr_done  out  1  one-cycle pulse, write resolved
wr_err  out  1  qualifies wr_done: write rejected
wr_slot  out  ID_W  slot actually written (0 on error)
rdy  out  1  high in IDLE; requests ignored while low
count  out  ID_W  number of valid slots
full  out  1  count == DEPTH

Behaviour:
- Reset: all outputs 0. Valid bits cleared. wr_ptr=0 (0-based). FSM enters INIT on the first clk edge with sys_rst_n=1. Reset asserted in any state aborts and re-enters INIT; a pending rd_valid/wr_done is suppressed.
- FSM INIT: one slot zeroed per cycle, index 0..DEPTH-1, DEPTH cycles total, rdy=0. Then IDLE, rdy=1. No other states.
- Read in IDLE: rd_req=1 gives rd_valid=1 next cycle (latency 1).
  - rd_err=1 if rd_id==0, rd_id>DEPTH, or the slot is invalid.
- Write in place, wr_id 1..DEPTH: slot written, valid set, count+1 only if the slot was previously invalid. wr_done next cycle, wr_slot=wr_id. wr_ptr unchanged.
- Write with wr_id>DEPTH: rejected, wr_err=1, no state change.
- Append, wr_id=0: target is wr_ptr.
  - Target empty: write, count+1, wr_ptr advances.
  - Target occupied, OVERWRITE=1: write, count unchanged, wr_ptr advances.
  - Target occupied, OVERWRITE=0: reject with wr_err, wr_ptr unchanged.
  - wr_ptr wraps DEPTH-1 -> 0.
  - wr_slot = target+1.
- Read and write in the same cycle are both accepted.
  - Same slot: the read returns pre-write data (read-before-write), and rd_err reflects the pre-write valid bit.
- Back-to-back requests every cycle are supported; throughput is 1 read plus 1 write per cycle.
- count and full update in the cycle wr_done asserts.

Optional Feature:
- Macro: RECORD_STORE_PRELOAD_EN.
- Defined: the INIT sweep writes a constant demo table from the package instead of zeros. Per-module parameter PRELOAD_CNT <= DEPTH. Slots 1..PRELOAD_CNT are set valid, count=PRELOAD_CNT, wr_ptr=PRELOAD_CNT mod DEPTH.
- Undefined: INIT clears everything, count=0. The preload constants are not compiled.

Decomposition:
- Shared package holds: ChartInfo, Chart, PlayRecord typedefs; CHARTS_MAX and PLAY_RECS_MAX used as DEPTH at instantiation; demo preload tables (guarded by the macro); a state enum {INIT, IDLE}.
- One sub-module, record_store_ram: DEPTH x DATA_W array with 1 read and 1 write port and synchronous read-before-write semantics. It is inferable as BRAM/LUTRAM.
- Valid bits, count, wr_ptr and the FSM stay in record_store.

Test Plan (DEPTH=4, DATA_W=16, OVERWRITE=1, macro undefined unless noted):
- Reset release -> rdy low exactly 4 cycles then high; count=0. rd_id=1 -> rd_valid with rd_err=1, rd_data=0.
- Append 0xA1, 0xA2, 0xA3, 0xA4 -> wr_slot 1, 2, 3, 4; full=1. Fifth append 0xA5 -> wr_slot=1, count stays 4; read id 1 -> 0xA5.
- OVERWRITE=0, same 5 appends -> fifth gives wr_err=1, wr_slot=0; slot 1 still 0xA1.
- Write in place id 3 = 0xBEEF while reading id 3 the same cycle (slot holds 0xA3) -> read returns 0xA3; next read returns 0xBEEF; count unchanged.
- rd_id=5 and wr_id=7 -> rd_err=1, wr_err=1, no state change. Reset asserted mid-stream -> no pulses, INIT replays.
- Macro defined, PRELOAD_CNT=2 -> after INIT count=2, slots 1-2 hold demo values; next append lands at wr_slot=3.
